// File: rtl/jesd_rx_pkg.sv
// Shared types and sizing helpers for the JESD204B receive sync controller.
package jesd_rx_pkg;

    typedef enum logic [1:0] {
        ALIGN     = 2'd0,
        CGS       = 2'd1,
        SYNC_WAIT = 2'd2,
        DATA      = 2'd3
    } jesd_state_e;

    // LMFC phase counter width; a single-cycle LMFC still needs one bit.
    function automatic int lmfc_cnt_width(input int period);
        return (period <= 1) ? 1 : $clog2(period);
    endfunction

    // Minimum-low counter must be able to hold the value LMFC_PERIOD itself.
    function automatic int min_low_width(input int period);
        return (period <= 1) ? 1 : $clog2(period + 1);
    endfunction

endpackage

// File: rtl/jesd_rx_sync_ctrl_sysref_capture.sv
// SYSREF capture: two-flop synchronizer, history flop and registered rising-edge pulse.
module sysref_capture (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sysref_i,
    output logic rise_o
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            rise_o <= 1'b0;
        end else begin
            s1     <= sysref_i;
            s2     <= s1;
            s3     <= s2;
            rise_o <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/jesd_rx_sync_ctrl.sv
// JESD204B subclass-1 receive link controller: SYSREF/LMFC alignment and SYNC~ sequencing.
// Optional SYSREF phase checking is built when JESD_SYSREF_CHECK_EN is defined.
//
// state     | meaning
// ALIGN     | waiting for a SYSREF edge to align the LMFC, SYNC~ low
// CGS       | SYNC~ low, counting minimum low time, waiting for all lanes
// SYNC_WAIT | lanes synced, waiting for the LMFC boundary to release SYNC~
// DATA      | SYNC~ released, link carrying data
module jesd_rx_sync_ctrl
    import jesd_rx_pkg::*;
#(
    parameter int  L           = 4,
    parameter int  K_FRAMES    = 32,
    parameter int  F_OCTETS    = 2,
    parameter int  LMFC_PERIOD = K_FRAMES * F_OCTETS / 4,
    localparam int CW          = lmfc_cnt_width(LMFC_PERIOD)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          sysref_i,
    input  logic          sysref_arm_i,
    input  logic [L-1:0]  cgs_done_i,
    input  logic          resync_req_i,
    output logic          sync_n_o,
    output logic          lmfc_o,
    output logic [CW-1:0] lmfc_cnt_o,
    output logic          sysref_aligned_o,
    output logic          sysref_err_o,
    output logic [1:0]    state_o
);

    localparam int            MW       = min_low_width(LMFC_PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(LMFC_PERIOD - 1);
    localparam logic [MW-1:0] ML_SAT   = MW'(LMFC_PERIOD);

    logic          rise;
    logic          realign;
    logic          at_last;
    logic          lanes_ok;
    logic          ml_sat;
    logic          ml_clr;
    logic          aligned_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [MW-1:0] ml_q;
    jesd_state_e   state_q;
    jesd_state_e   state_d;

    sysref_capture u_sysref_capture (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .sysref_i (sysref_i),
        .rise_o   (rise)
    );

    assign lanes_ok = &cgs_done_i;
    assign at_last  = (cnt_q == CNT_LAST);
    assign ml_sat   = (ml_q == ML_SAT);
    // An armed edge realigns even when already aligned.
    assign realign  = rise & (~aligned_q | sysref_arm_i);
    assign cnt_d    = (realign || at_last) ? '0 : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        ml_clr  = 1'b0;
        if (sysref_arm_i) begin
            state_d = realign ? CGS : ALIGN;
            ml_clr  = 1'b1;
        end else begin
            case (state_q)
                ALIGN: begin
                    if (realign) begin
                        state_d = CGS;
                        ml_clr  = 1'b1;
                    end
                end
                CGS: begin
                    if (resync_req_i) begin
                        ml_clr = 1'b1;
                    end else if (ml_sat && lanes_ok) begin
                        state_d = SYNC_WAIT;
                    end
                end
                SYNC_WAIT: begin
                    if (resync_req_i) begin
                        state_d = CGS;
                        ml_clr  = 1'b1;
                    end else if (!lanes_ok) begin
                        state_d = CGS;
                    end else if (at_last) begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (resync_req_i || !lanes_ok) begin
                        state_d = CGS;
                        ml_clr  = 1'b1;
                    end
                end
                default: begin
                    state_d = ALIGN;
                    ml_clr  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ALIGN;
            sync_n_o  <= 1'b0;
            cnt_q     <= '0;
            lmfc_o    <= 1'b1;
            aligned_q <= 1'b0;
            ml_q      <= '0;
        end else begin
            state_q  <= state_d;
            sync_n_o <= (state_d == DATA);
            cnt_q    <= cnt_d;
            lmfc_o   <= (cnt_d == '0);
            if (realign) begin
                aligned_q <= 1'b1;
            end else if (sysref_arm_i) begin
                aligned_q <= 1'b0;
            end
            if (ml_clr) begin
                ml_q <= '0;
            end else if (state_q == CGS && !ml_sat) begin
                ml_q <= ml_q + MW'(1);
            end
        end
    end

`ifdef JESD_SYSREF_CHECK_EN
    logic err_q;

    // Once aligned, a SYSREF edge is only legal in the last LMFC cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else if (sysref_arm_i) begin
            err_q <= 1'b0;
        end else if (rise && aligned_q && !at_last) begin
            err_q <= 1'b1;
        end
    end

    assign sysref_err_o = err_q;
`else
    assign sysref_err_o = 1'b0;
`endif

    assign lmfc_cnt_o       = cnt_q;
    assign sysref_aligned_o = aligned_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_jesd_rx_sync_ctrl.sv
// Scoreboard bench for jesd_rx_sync_ctrl: LMFC_PERIOD=16 and LMFC_PERIOD=1 instances share stimulus.
`timescale 1ns/1ps
module tb_jesd_rx_sync_ctrl;

`ifdef JESD_SYSREF_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        int a;
        int e;
        int st;
        bit aligned;
        bit err;
    } mdl_t;

    typedef struct {
        int n;
        int cnt;
        bit lmfc;
        bit sync_n;
        bit aligned;
        bit err;
        int st;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sysref = 1'b0;
    logic       arm = 1'b0;
    logic       resync = 1'b0;
    logic [3:0] lanes = 4'h0;

    logic       sync_n16, lmfc16, al16, err16;
    logic [3:0] cnt16;
    logic [1:0] st16;
    logic       sync_n1, lmfc1, al1, err1;
    logic [0:0] cnt1;
    logic [1:0] st1;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   samp [0:8191];
    mdl_t m16, m1;
    exp_t q16 [$];
    exp_t q1 [$];
    exp_t mx;
    logic prev16 = 1'b0;
    logic prev1 = 1'b0;
    int   rises [0:5] = '{20, 84, 148, 212, 281, 340};

    jesd_rx_sync_ctrl #(.L(4), .K_FRAMES(32), .F_OCTETS(2)) dut16 (
        .clk_i(clk), .rst_n_i(rst_n), .sysref_i(sysref), .sysref_arm_i(arm),
        .cgs_done_i(lanes), .resync_req_i(resync), .sync_n_o(sync_n16), .lmfc_o(lmfc16),
        .lmfc_cnt_o(cnt16), .sysref_aligned_o(al16), .sysref_err_o(err16), .state_o(st16)
    );

    jesd_rx_sync_ctrl #(.L(4), .K_FRAMES(2), .F_OCTETS(2)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .sysref_i(sysref), .sysref_arm_i(arm),
        .cgs_done_i(lanes), .resync_req_i(resync), .sync_n_o(sync_n1), .lmfc_o(lmfc1),
        .lmfc_cnt_o(cnt1), .sysref_aligned_o(al1), .sysref_err_o(err1), .state_o(st1)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic bit sget(int k);
        return (k < 1) ? 1'b0 : samp[k];
    endfunction

    function automatic int pmod(int x, int p);
        return ((x % p) + p) % p;
    endfunction

    function automatic mdl_t mreset();
        mdl_t m;
        m.a = 0; m.e = 0; m.st = 0; m.aligned = 1'b0; m.err = 1'b0;
        return m;
    endfunction

    // Behavioural link model for edge n: LMFC phase is (time since last alignment) mod p,
    // minimum SYNC~ low time is (time since CGS entry).
    function automatic mdl_t mstep(mdl_t m, int n, int p, bit rise, bit a_in, bit rs, bit ok);
        bit last;
        bit realign;
        last    = (pmod(n - 1 - m.a, p) == p - 1);
        realign = rise && (!m.aligned || a_in);
        if (a_in) m.err = 1'b0;
        else if (CHK && rise && m.aligned && !last) m.err = 1'b1;
        if (a_in) begin
            m.st = realign ? 1 : 0;
            m.e  = n;
        end else begin
            case (m.st)
                0: if (realign) begin m.st = 1; m.e = n; end
                1: if (rs) m.e = n;
                   else if ((n - 1 - m.e) >= p && ok) m.st = 2;
                2: if (rs) begin m.st = 1; m.e = n; end
                   else if (!ok) m.st = 1;
                   else if (last) m.st = 3;
                default: if (rs || !ok) begin m.st = 1; m.e = n; end
            endcase
        end
        if (realign) begin
            m.aligned = 1'b1;
            m.a       = n;
        end else if (a_in) begin
            m.aligned = 1'b0;
        end
        return m;
    endfunction

    function automatic exp_t mexp(mdl_t m, int n, int p);
        exp_t x;
        x.n       = n;
        x.cnt     = pmod(n - m.a, p);
        x.lmfc    = (x.cnt == 0);
        x.sync_n  = (m.st == 3);
        x.aligned = m.aligned;
        x.err     = m.err;
        x.st      = m.st;
        return x;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %0d want %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic cmp(string nm, exp_t x, logic [3:0] cnt, logic lm, logic sn,
                       logic al, logic er, logic [1:0] st);
        tests++;
        if (cnt !== 4'(x.cnt) || lm !== x.lmfc || sn !== x.sync_n || al !== x.aligned ||
            er !== x.err || st !== 2'(x.st)) begin
            fails++;
            $display("FAIL %s cyc=%0d got cnt=%0d lmfc=%b sync_n=%b aligned=%b err=%b state=%0d want cnt=%0d lmfc=%b sync_n=%b aligned=%b err=%b state=%0d",
                     nm, cyc, cnt, lm, sn, al, er, st,
                     x.cnt, x.lmfc, x.sync_n, x.aligned, x.err, x.st);
        end
    endtask

    // Applies inputs for the next edge, pushes both expectations, then waits past that edge.
    task automatic drive(bit sr, bit a_in, bit rs, logic [3:0] ln);
        int n;
        bit rise;
        sysref = sr; arm = a_in; resync = rs; lanes = ln;
        n = cyc + 1;
        if (n <= 8191) samp[n] = sr;
        rise = sget(n - 3) && !sget(n - 4);
        m16 = mstep(m16, n, 16, rise, a_in, rs, &ln);
        m1  = mstep(m1, n, 1, rise, a_in, rs, &ln);
        q16.push_back(mexp(m16, n, 16));
        q1.push_back(mexp(m1, n, 1));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (q16.size() > 0 && q16[0].n == cyc) begin
                mx = q16.pop_front();
                cmp("dut16", mx, cnt16, lmfc16, sync_n16, al16, err16, st16);
            end
            if (q1.size() > 0 && q1[0].n == cyc) begin
                mx = q1.pop_front();
                cmp("dut1", mx, {3'b000, cnt1}, lmfc1, sync_n1, al1, err1, st1);
            end
            if (sync_n16 === 1'b1 && prev16 === 1'b0) begin
                tests++;
                if (lmfc16 !== 1'b1) begin
                    fails++;
                    $display("FAIL sync_release_on_lmfc cyc=%0d: got lmfc=%b want 1", cyc, lmfc16);
                end
            end
            if (sync_n1 === 1'b1 && prev1 === 1'b0) begin
                tests++;
                if (lmfc1 !== 1'b1) begin
                    fails++;
                    $display("FAIL sync_release_on_lmfc_p1 cyc=%0d: got lmfc=%b want 1", cyc, lmfc1);
                end
            end
            prev16 = sync_n16;
            prev1  = sync_n1;
        end else begin
            prev16 = 1'b0;
            prev1  = 1'b0;
        end
    end

    initial begin
        int next_r;
        int last_r;
        int hold_arm;
        int drop;
        logic [3:0] dmask;
        bit reached;

        m16 = mreset();
        m1  = mreset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sync_n", 32'(sync_n16), 0);
        chk("rst_cnt", 32'(cnt16), 0);
        chk("rst_lmfc", 32'(lmfc16), 1);
        chk("rst_aligned", 32'(al16), 0);
        chk("rst_err", 32'(err16), 0);
        chk("rst_state", 32'(st16), 0);
        rst_n = 1'b1;

        // Directed: align, release, lane loss, periodic/shifted SYSREF, arm.
        for (int n = 1; n <= 360; n++) begin
            bit sr;
            logic [3:0] ln;
            sr = 1'b0;
            for (int i = 0; i < 6; i++)
                if (n >= rises[i] && n < rises[i] + 4) sr = 1'b1;
            ln = (n < 26) ? 4'h0 : ((n == 61) ? 4'b1011 : 4'hF);
            drive(sr, n == 300, 1'b0, ln);
            case (n)
                23: begin
                    chk("align_cnt", 32'(cnt16), 0);
                    chk("align_lmfc", 32'(lmfc16), 1);
                    chk("align_aligned", 32'(al16), 1);
                    chk("align_state", 32'(st16), 1);
                end
                54: chk("sync_low_before_boundary", 32'(sync_n16), 0);
                55: begin
                    chk("sync_release", 32'(sync_n16), 1);
                    chk("sync_release_cnt", 32'(cnt16), 0);
                end
                61: begin
                    chk("lane_loss_sync_n", 32'(sync_n16), 0);
                    chk("lane_loss_state", 32'(st16), 1);
                end
                86: chk("relink_held_low", 32'(sync_n16), 0);
                87: begin
                    chk("relink_release", 32'(sync_n16), 1);
                    chk("relink_lmfc", 32'(lmfc16), 1);
                end
                280: chk("periodic_no_err", 32'(err16), 0);
                284: begin
                    chk("shifted_err", 32'(err16), 32'(CHK));
                    chk("shifted_phase_kept", 32'(cnt16), 5);
                end
                300: begin
                    chk("arm_err_clear", 32'(err16), 0);
                    chk("arm_aligned_clear", 32'(al16), 0);
                    chk("arm_state", 32'(st16), 0);
                end
                343: begin
                    chk("rearm_cnt", 32'(cnt16), 0);
                    chk("rearm_aligned", 32'(al16), 1);
                    chk("rearm_state", 32'(st16), 1);
                end
                default: ;
            endcase
        end

        // Randomized traffic.
        next_r   = cyc + 40;
        last_r   = -100;
        hold_arm = 0;
        drop     = 0;
        dmask    = 4'h0;
        for (int i = 0; i < 2500; i++) begin
            int n;
            bit sr;
            bit a_in;
            bit rs;
            logic [3:0] ln;
            n = cyc + 1;
            if (n == next_r) begin
                last_r = n;
                next_r = n + 64 * $urandom_range(1, 2) +
                         (($urandom_range(0, 5) == 0) ? $urandom_range(1, 15) : 0);
            end
            sr = ((n - last_r) < 4);
            if (hold_arm == 0 && $urandom_range(0, 299) == 0) hold_arm = $urandom_range(1, 3);
            a_in = (hold_arm > 0);
            if (hold_arm > 0) hold_arm--;
            if (drop == 0 && $urandom_range(0, 79) == 0) begin
                drop  = $urandom_range(1, 3);
                dmask = 4'($urandom_range(1, 15));
            end
            ln = (drop > 0) ? ~dmask : 4'hF;
            if (drop > 0) drop--;
            rs = ($urandom_range(0, 199) == 0);
            drive(sr, a_in, rs, ln);
        end

        // Bring the link to DATA away from an LMFC boundary, then reset asynchronously.
        reached = 1'b0;
        for (int i = 0; i < 400 && !reached; i++) begin
            drive((i % 64) < 4, 1'b0, 1'b0, 4'hF);
            if (m16.st == 3 && pmod(cyc - m16.a, 16) != 0) reached = 1'b1;
        end
        chk("reach_data_mid_lmfc", 32'(reached), 1);
        #2;
        q16.delete();
        q1.delete();
        rst_n = 1'b0;
        #1;
        chk("async_rst_sync_n", 32'(sync_n16), 0);
        chk("async_rst_cnt", 32'(cnt16), 0);
        chk("async_rst_lmfc", 32'(lmfc16), 1);
        chk("async_rst_aligned", 32'(al16), 0);
        chk("async_rst_err", 32'(err16), 0);
        chk("async_rst_state", 32'(st16), 0);
        repeat (2) @(posedge clk);
        #1;
        foreach (samp[i]) samp[i] = 1'b0;
        m16 = mreset();
        m1  = mreset();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) drive((i >= 5 && i < 9), 1'b0, 1'b0, 4'hF);
        #10;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jesd_rx_sync_ctrl.md
# jesd_rx_sync_ctrl

Subclass-1 JESD204B receive-side link controller sitting directly downstream of the ADC pin PHY. Consumes the single-ended SYSREF from the PHY, aligns a local LMFC counter to it, and drives the single-ended SYNC~ request that the PHY converts to differential for the ADC. Tracks per-lane code-group-sync status and runs the SYNC~ request / release / resync state machine on the device clock.

## Interface
- L, 4, lane count (1..8)
- K_FRAMES, 32, frames per multiframe
- F_OCTETS, 2, octets per frame
- LMFC_PERIOD, K_FRAMES*F_OCTETS/4, device-clock cycles per LMFC (4 octets/cycle); must be an integer ≥1
- clk_i  in  1  device clock; one clock, all logic on it
- rst_n_i  in  1  reset, asynchronous, active-low
- sysref_i  in  1  SYSREF from PHY, asynchronous to clk_i
- sysref_arm_i  in  1  level; request realignment on the next SYSREF edge
- cgs_done_i  in  L  per-lane code group sync achieved
- resync_req_i  in  1  one-cycle pulse; force link resync
- sync_n_o  out  1  SYNC~ to PHY, active low
- lmfc_o  out  1  one-cycle LMFC boundary pulse
- lmfc_cnt_o  out  CW=max(1,$clog2(LMFC_PERIOD))  LMFC phase
- sysref_aligned_o  out  1  LMFC aligned to a SYSREF edge
- sysref_err_o  out  1  sticky: SYSREF edge off LMFC phase
- state_o  out  2  FSM state

## Operation
- Reset values: sync_n_o=0, lmfc_cnt_o=0, lmfc_o=1, sysref_aligned_o=0, sysref_err_o=0, state_o=ALIGN.
- SYSREF capture: 2-flop synchronizer + 1 history flop; rise = s2 & ~s3.
- LMFC counter free-runs 0..LMFC_PERIOD-1, wraps to 0; lmfc_o registered, high exactly when lmfc_cnt_o==0. LMFC_PERIOD=1: lmfc_cnt_o stuck 0, lmfc_o constantly 1.
- Realign: on rise while sysref_aligned_o=0, counter loads 0 next cycle, sysref_aligned_o set.
- sysref_arm_i high: clears sysref_aligned_o and sysref_err_o, FSM -> ALIGN. Held high: every edge realigns.
- FSM states (state_o encoding): ALIGN=0, CGS=1, SYNC_WAIT=2, DATA=3.
  - ALIGN: sync_n_o=0; on realign -> CGS, min-low counter cleared.
  - CGS: sync_n_o=0; min-low counter saturates at LMFC_PERIOD; when saturated and &cgs_done_i -> SYNC_WAIT.
  - SYNC_WAIT: sync_n_o=0; any cgs_done_i low -> CGS (counter kept); when lmfc_cnt_o==LMFC_PERIOD-1 -> DATA.
  - DATA: sync_n_o=1; resync_req_i or any cgs_done_i low -> CGS, min-low counter cleared.
- Priority: rst_n_i > sysref_arm_i > resync_req_i > cgs_done_i loss.
- sync_n_o registered directly from next-state (no glitch).

## Timing
- sysref_i rising sampled at edge k: lmfc_cnt_o=0, lmfc_o=1 after edge k+3 (3 cycles).
- SYNC~ release coincides with LMFC boundary: sync_n_o rises in the same cycle lmfc_o=1.
- Minimum SYNC~ low after any entry to CGS: LMFC_PERIOD cycles.
- DATA -> CGS: sync_n_o low one cycle after the trigger.
- Arm and rise in same cycle: arm takes effect, realign occurs on that rise.

## Configuration
- JESD_SYSREF_CHECK_EN defined: after alignment, every rise with lmfc_cnt_o≠LMFC_PERIOD-1 sets sysref_err_o (sticky until arm or reset); counter not moved. Periodic SYSREF at integer multiples of LMFC never flags.
- Undefined: sysref_err_o tied 0; post-alignment edges ignored.

## Structure
- Package jesd_rx_pkg: state enum (ALIGN/CGS/SYNC_WAIT/DATA), LMFC_PERIOD/width helper function.
- Sub-module sysref_capture: synchronizer + rise detect, output rise pulse.

## Test plan
- L=4, LMFC_PERIOD=16; reset, SYSREF rise at edge 20 -> lmfc_cnt_o=0 after edge 23, sysref_aligned_o=1, state_o=1.
- All cgs_done_i high 2 cycles after alignment -> sync_n_o stays 0 until 16 low cycles done, rises exactly when lmfc_cnt_o==0.
- In DATA, cgs_done_i[2] low one cycle -> sync_n_o=0 next cycle, held ≥16 cycles, re-release on LMFC boundary.
- CHECK_EN: periodic SYSREF every 64 cycles -> sysref_err_o=0; one edge shifted 5 cycles -> sysref_err_o=1, lmfc phase unchanged; arm pulse -> err cleared, realign on next edge.
- LMFC_PERIOD=1 -> lmfc_o constantly 1, sync_n_o rises one cycle after CGS saturation with lanes done.
- rst_n_i asserted in DATA mid-LMFC -> all outputs to reset values immediately (asynchronous).
